// File: rtl/exe_stage_pkg.sv
// Shared types and constants for the execute stage: ALU command codes, shift types,
// status-register bit positions and the EXE/MEM data payload.
package exe_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned SHOP_W  = 12;
  localparam int unsigned IMM24_W = 24;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned SR_W    = 4;

  // Status register layout is {N,Z,C,V}
  localparam int unsigned SR_N = 3;
  localparam int unsigned SR_Z = 2;
  localparam int unsigned SR_C = 1;
  localparam int unsigned SR_V = 0;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef struct packed {
    logic [XLEN-1:0]  alu_res;
    logic [XLEN-1:0]  val_rm;
    logic [REG_W-1:0] dest;
  } exe_mem_t;

  // Rotate right by 0..31; the doubled word keeps amount 0 well defined.
  function automatic logic [XLEN-1:0] ror32(input logic [XLEN-1:0] x, input logic [4:0] n);
    logic [2*XLEN-1:0] t;
    t = {x, x} >> n;
    return t[XLEN-1:0];
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// Execute-stage bundle: decoded instruction in, EXE/MEM register and branch info out.
interface exe_stage_if;
  import exe_stage_pkg::*;

  logic                 freeze;
  logic                 flush;
  logic                 in_valid;
  logic [CMD_W-1:0]     exe_cmd;
  logic                 s_bit;
  logic                 imm;
  logic                 mem_r_en;
  logic                 mem_w_en;
  logic                 wb_en;
  logic                 b_in;
  logic [XLEN-1:0]      pc_in;
  logic [XLEN-1:0]      val1;
  logic [XLEN-1:0]      val_rm;
  logic [SHOP_W-1:0]    shift_operand;
  logic [IMM24_W-1:0]   signed_imm24;
  logic [REG_W-1:0]     dest;

  logic                 out_valid;
  logic [XLEN-1:0]      alu_res;
  logic [XLEN-1:0]      val_rm_out;
  logic [REG_W-1:0]     dest_out;
  logic                 mem_r_en_out;
  logic                 mem_w_en_out;
  logic                 wb_en_out;
  logic [SR_W-1:0]      sr;
  logic                 br_taken;
  logic [XLEN-1:0]      br_addr;

  modport master (
    output freeze, flush, in_valid, exe_cmd, s_bit, imm, mem_r_en, mem_w_en, wb_en, b_in,
           pc_in, val1, val_rm, shift_operand, signed_imm24, dest,
    input  out_valid, alu_res, val_rm_out, dest_out, mem_r_en_out, mem_w_en_out, wb_en_out,
           sr, br_taken, br_addr
  );

  modport slave (
    input  freeze, flush, in_valid, exe_cmd, s_bit, imm, mem_r_en, mem_w_en, wb_en, b_in,
           pc_in, val1, val_rm, shift_operand, signed_imm24, dest,
    output out_valid, alu_res, val_rm_out, dest_out, mem_r_en_out, mem_w_en_out, wb_en_out,
           sr, br_taken, br_addr
  );

endinterface

// File: rtl/exe_stage_alu.sv
// Combinational ALU. carry_c is a true carry for additions and a borrow for subtractions;
// arith_c flags the commands whose C and V results are meaningful.
module exe_stage_alu
  import exe_stage_pkg::*;
(
  input  logic [CMD_W-1:0] cmd,
  input  logic [XLEN-1:0]  val1,
  input  logic [XLEN-1:0]  val2,
  input  logic             cin,
  output logic [XLEN-1:0]  res_c,
  output logic             carry_c,
  output logic             ovf_c,
  output logic             arith_c
);

  logic [XLEN:0] wide;

  always_comb begin
    wide    = '0;
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    arith_c = 1'b0;
    case (exe_cmd_e'(cmd))
      CMD_MOV: res_c = val2;
      CMD_MVN: res_c = ~val2;
      CMD_AND: res_c = val1 & val2;
      CMD_ORR: res_c = val1 | val2;
      CMD_EOR: res_c = val1 ^ val2;
      CMD_ADD, CMD_ADC: begin
        wide    = {1'b0, val1} + {1'b0, val2} +
                  ((exe_cmd_e'(cmd) == CMD_ADC) ? (XLEN+1)'(cin) : '0);
        res_c   = wide[XLEN-1:0];
        carry_c = wide[XLEN];
        ovf_c   = (val1[XLEN-1] == val2[XLEN-1]) && (res_c[XLEN-1] != val1[XLEN-1]);
        arith_c = 1'b1;
      end
      CMD_SUB, CMD_SBC: begin
        // With C holding a borrow, SBC subtracts the previous borrow directly
        wide    = {1'b0, val1} - {1'b0, val2} -
                  ((exe_cmd_e'(cmd) == CMD_SBC) ? (XLEN+1)'(cin) : '0);
        res_c   = wide[XLEN-1:0];
        carry_c = wide[XLEN];
        ovf_c   = (val1[XLEN-1] != val2[XLEN-1]) && (res_c[XLEN-1] != val1[XLEN-1]);
        arith_c = 1'b1;
      end
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: second-operand generation, ALU, status register, branch target and the
// EXE/MEM pipeline register with freeze/flush control.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  exe_stage_if.slave   bus
);

  logic [XLEN-1:0] val2;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res_c;
  logic            carry_c;
  logic            ovf_c;
  logic            arith_c;
  logic [SR_W-1:0] sr_q;
  logic [SR_W-1:0] sr_next;
  logic            out_valid_q;
  logic            mem_r_en_q;
  logic            mem_w_en_q;
  logic            wb_en_q;
  exe_mem_t        data_q;

  assign shamt = bus.shift_operand[11:7];

  // Second operand: memory offset, rotated immediate, or immediate-shifted register
  always_comb begin
    val2 = bus.val_rm;
    if (bus.mem_r_en || bus.mem_w_en) begin
      val2 = XLEN'(bus.shift_operand);
    end else if (bus.imm) begin
      val2 = ror32(XLEN'(bus.shift_operand[7:0]), {bus.shift_operand[11:8], 1'b0});
    end else if (!bus.shift_operand[4]) begin
      case (shift_e'(bus.shift_operand[6:5]))
        SH_LSL:  val2 = bus.val_rm << shamt;
        SH_LSR:  val2 = bus.val_rm >> shamt;
        SH_ASR:  val2 = $unsigned($signed(bus.val_rm) >>> shamt);
        default: val2 = ror32(bus.val_rm, shamt);
      endcase
    end
  end

  exe_stage_alu u_alu (
    .cmd     (bus.exe_cmd),
    .val1    (bus.val1),
    .val2    (val2),
    .cin     (sr_q[SR_C]),
    .res_c   (alu_res_c),
    .carry_c (carry_c),
    .ovf_c   (ovf_c),
    .arith_c (arith_c)
  );

  always_comb begin
    sr_next       = sr_q;
    sr_next[SR_N] = alu_res_c[XLEN-1];
    sr_next[SR_Z] = (alu_res_c == '0);
    if (arith_c) begin
      sr_next[SR_C] = carry_c;
      sr_next[SR_V] = ovf_c;
    end
  end

  // Flush kills control bits but keeps data and flags; freeze holds everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      mem_r_en_q  <= 1'b0;
      mem_w_en_q  <= 1'b0;
      wb_en_q     <= 1'b0;
      data_q      <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      mem_r_en_q  <= 1'b0;
      mem_w_en_q  <= 1'b0;
      wb_en_q     <= 1'b0;
    end else if (!bus.freeze) begin
      out_valid_q <= bus.in_valid;
      mem_r_en_q  <= bus.mem_r_en && bus.in_valid;
      mem_w_en_q  <= bus.mem_w_en && bus.in_valid;
      wb_en_q     <= bus.wb_en && bus.in_valid;
      data_q      <= '{alu_res: alu_res_c, val_rm: bus.val_rm, dest: bus.dest};
      if (bus.in_valid && bus.s_bit) begin
        sr_q <= sr_next;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.alu_res      = data_q.alu_res;
  assign bus.val_rm_out   = data_q.val_rm;
  assign bus.dest_out     = data_q.dest;
  assign bus.mem_r_en_out = mem_r_en_q;
  assign bus.mem_w_en_out = mem_w_en_q;
  assign bus.wb_en_out    = wb_en_q;
  assign bus.sr           = sr_q;

  assign bus.br_taken = bus.in_valid && bus.b_in && !bus.freeze && !bus.flush;
  assign bus.br_addr  = bus.pc_in + {{6{bus.signed_imm24[IMM24_W-1]}}, bus.signed_imm24, 2'b00};

endmodule
